memory_access_sequencer: RTL

Multi-cycle load/store sequencer that replaces the fixed LOAD/STORE_PRELOAD/STORE/NOP memory mode scheme.
- Parametrised in data width (XLEN), address width and memory read latency.
- Adds a request/busy/done handshake, read-modify-write for sub-word stores, and misalignment/illegal-width detection.
- Sits between the instruction decoder/control and the synchronous data memory; its loadData feeds the register file's memory writeback source.

---
 rtl/memory_access_sequencer_pkg.sv | 60 ++++++
 rtl/memory_access_sequencer_aligner.sv | 57 +++++
 rtl/memory_access_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/memory_access_sequencer_pkg.sv
// Shared types and width/alignment helpers for the load/store sequencer.
package memory_access_sequencer_pkg;

  typedef enum logic [2:0] {
    MW_BYTE   = 3'b000,
    MW_HALF   = 3'b001,
    MW_WORD   = 3'b010,
    MW_DOUBLE = 3'b011,
    MW_BYTE_U = 3'b100,
    MW_HALF_U = 3'b101,
    MW_WORD_U = 3'b110
  } MemWidth_t;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_READ  = 3'd1,
    SEQ_WAIT  = 3'd2,
    SEQ_WRITE = 3'd3,
    SEQ_DONE  = 3'd4
  } SequencerState_t;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;

  typedef logic ErrorFlag_t;
  typedef logic WriteEnable_t;

  // 'wide' enables the doubleword / unsigned-word encodings of a 64-bit core.
  function automatic logic isLegalWidth(input logic isStore, input logic [2:0] funct3,
                                        input logic wide);
    logic legal;
    legal = 1'b0;
    if (isStore) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        3'b011:                 legal = wide;
        default:                legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        3'b011, 3'b110:                         legal = wide;
        default:                                legal = 1'b0;
      endcase
    end
    return legal;
  endfunction

  function automatic logic isMisaligned(input logic [2:0] addrLow, input logic [1:0] sizeLog2);
    logic mis;
    case (sizeLog2)
      2'd0:    mis = 1'b0;
      2'd1:    mis = addrLow[0];
      2'd2:    mis = |addrLow[1:0];
      default: mis = |addrLow;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/memory_access_sequencer_aligner.sv
// Combinational lane logic: extracts and extends load data, merges sub-word store data.
module load_store_aligner
  import memory_access_sequencer_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BYTES     = XLEN / 8,
  parameter int LANE_BITS = $clog2(XLEN / 8)
) (
  input  logic [2:0]           i_funct3,
  input  logic [LANE_BITS-1:0] i_lane,
  input  logic [XLEN-1:0]      i_readWord,
  input  logic [XLEN-1:0]      i_storeData,
  output logic [XLEN-1:0]      o_loadData,
  output logic [XLEN-1:0]      o_mergedWord
);

  logic [XLEN-1:0]  w_shiftedRead;
  logic [XLEN-1:0]  w_shiftedStore;
  logic [BYTES-1:0] w_sizeMask;
  logic [BYTES-1:0] w_laneMask;

  assign w_shiftedRead  = i_readWord >> {i_lane, 3'b000};
  assign w_shiftedStore = i_storeData << {i_lane, 3'b000};

  always_comb begin
    o_loadData = w_shiftedRead;
    case (MemWidth_t'(i_funct3))
      MW_BYTE:   o_loadData = XLEN'($signed(w_shiftedRead[7:0]));
      MW_HALF:   o_loadData = XLEN'($signed(w_shiftedRead[15:0]));
      MW_WORD:   o_loadData = XLEN'($signed(w_shiftedRead[31:0]));
      MW_BYTE_U: o_loadData = XLEN'(w_shiftedRead[7:0]);
      MW_HALF_U: o_loadData = XLEN'(w_shiftedRead[15:0]);
      MW_WORD_U: o_loadData = XLEN'(w_shiftedRead[31:0]);
      default:   o_loadData = w_shiftedRead;
    endcase
  end

  always_comb begin
    w_sizeMask = '1;
    case (i_funct3[1:0])
      2'd0:    w_sizeMask = BYTES'(1);
      2'd1:    w_sizeMask = BYTES'(3);
      2'd2:    w_sizeMask = BYTES'(15);
      default: w_sizeMask = '1;
    endcase
  end

  assign w_laneMask = w_sizeMask << i_lane;

  always_comb begin
    o_mergedWord = i_readWord;
    for (int b = 0; b < BYTES; b++) begin
      if (w_laneMask[b]) o_mergedWord[8*b +: 8] = w_shiftedStore[8*b +: 8];
    end
  end

endmodule

// File: rtl/memory_access_sequencer.sv
// Multi-cycle load/store sequencer: request/busy/done handshake, read-modify-write
// for sub-word stores, misalignment and illegal-width detection.
module memory_access_sequencer
  import memory_access_sequencer_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1,
  parameter int LANE_BITS    = $clog2(XLEN / 8)
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_request,
  input  logic                          i_isStore,
  input  logic [2:0]                    i_funct3,
  input  logic [ADDR_WIDTH-1:0]         i_byteAddress,
  input  logic [XLEN-1:0]               i_storeData,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [XLEN-1:0]               o_loadData,
  output logic                          o_accessError,
  output logic [ADDR_WIDTH-LANE_BITS-1:0] o_memAddress,
  output logic                          o_memReadEnable,
  input  logic [XLEN-1:0]               i_memReadData,
  output logic                          o_memWriteEnable,
  output logic [XLEN-1:0]               o_memWriteData
);

  localparam int CNT_BITS = $clog2(READ_LATENCY_MAX + 1);
  localparam logic WIDE   = (XLEN == 64);

  SequencerState_t              r_state;
  logic                         r_isStore;
  logic [2:0]                   r_funct3;
  logic [LANE_BITS-1:0]         r_lane;
  logic [XLEN-1:0]              r_storeData;
  logic [XLEN-1:0]              r_loadData;
  logic [XLEN-1:0]              r_writeData;
  logic [ADDR_WIDTH-LANE_BITS-1:0] r_memAddress;
  logic [CNT_BITS-1:0]          r_count;
  ErrorFlag_t                   r_accessError;

  logic            w_reqError;
  logic            w_fullStore;
  logic [XLEN-1:0] w_alignedLoad;
  logic [XLEN-1:0] w_mergedWord;

  assign w_reqError = !isLegalWidth(i_isStore, i_funct3, WIDE)
                    || isMisaligned(i_byteAddress[2:0], i_funct3[1:0]);
  // A store covering the whole word needs no read; everything narrower is RMW.
  assign w_fullStore = i_isStore && (i_funct3[1:0] == 2'(LANE_BITS));

  load_store_aligner #(.XLEN(XLEN)) u_aligner (
    .i_funct3     (r_funct3),
    .i_lane       (r_lane),
    .i_readWord   (i_memReadData),
    .i_storeData  (r_storeData),
    .o_loadData   (w_alignedLoad),
    .o_mergedWord (w_mergedWord)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= SEQ_IDLE;
      r_isStore     <= 1'b0;
      r_funct3      <= '0;
      r_lane        <= '0;
      r_storeData   <= '0;
      r_loadData    <= '0;
      r_writeData   <= '0;
      r_memAddress  <= '0;
      r_count       <= '0;
      r_accessError <= 1'b0;
    end else begin
      case (r_state)
        SEQ_IDLE: begin
          if (i_request) begin
            r_isStore   <= i_isStore;
            r_funct3    <= i_funct3;
            r_lane      <= i_byteAddress[LANE_BITS-1:0];
            r_storeData <= i_storeData;
            if (w_reqError) begin
              r_accessError <= 1'b1;
              r_state       <= SEQ_DONE;
            end else begin
              r_accessError <= 1'b0;
              r_memAddress  <= i_byteAddress[ADDR_WIDTH-1:LANE_BITS];
              if (w_fullStore) begin
                r_writeData <= i_storeData;
                r_state     <= SEQ_WRITE;
              end else begin
                r_state <= SEQ_READ;
              end
            end
          end
        end
        SEQ_READ: begin
          r_count <= CNT_BITS'(READ_LATENCY);
          r_state <= SEQ_WAIT;
        end
        SEQ_WAIT: begin
          r_count <= r_count - 1'b1;
          // Read data is valid in the last WAIT cycle.
          if (r_count == CNT_BITS'(1)) begin
            if (r_isStore) begin
              r_writeData <= w_mergedWord;
              r_state     <= SEQ_WRITE;
            end else begin
              r_loadData <= w_alignedLoad;
              r_state    <= SEQ_DONE;
            end
          end
        end
        SEQ_WRITE: r_state <= SEQ_DONE;
        SEQ_DONE:  r_state <= SEQ_IDLE;
        default:   r_state <= SEQ_IDLE;
      endcase
    end
  end

  WriteEnable_t w_writeEnable;
  assign w_writeEnable = (r_state == SEQ_WRITE) && !i_reset;

  assign o_busy           = (r_state != SEQ_IDLE);
  assign o_done           = (r_state == SEQ_DONE);
  assign o_loadData       = r_loadData;
  assign o_accessError    = r_accessError;
  assign o_memAddress     = r_memAddress;
  assign o_memReadEnable  = (r_state == SEQ_READ) && !i_reset;
  assign o_memWriteEnable = w_writeEnable;
  assign o_memWriteData   = r_writeData;

endmodule
